ro_sweep_ctrl: RTL

Sequencer for the ring-oscillator characterization array. It drives the shared stage-select and `start` controls of the 16 oscillator macros, plus the 4-bit oscillator select and 3-bit tap select of the output multiplexers. It sweeps every oscillator/tap combination, counts the edges of the selected (externally divided) oscillator output over a programmable gate window, and hands each result out over a valid/ready interface. It sits between the register/IO layer and the oscillator + mux16x1 datapath.

---
 rtl/ro_sweep_ctrl.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/ro_sweep_ctrl.sv
// ---------------------------------------------------------------------------
// ro_sweep_ctrl
//
// Sweep sequencer for the ring-oscillator characterization array. For every
// oscillator/tap pair it drives the mux selects, lets the selection settle,
// enables the oscillators, lets them settle, then counts rising edges of the
// (divided, asynchronous) selected oscillator output over a programmable
// gate window. Each result is offered on a valid/ready port.
//
// Ports
//   wb_clk_i, wb_rst_ni      clock, asynchronous active-low reset
//   sweep_go                 one-cycle start pulse, honoured only when idle
//   abort                    level, terminates any sweep in progress
//   cfg_stage, cfg_gate      stage pattern / gate length, latched on go
//   ro_in                    asynchronous oscillator output from the tap mux
//   ro_start, ro_stage       oscillator enable and stage pattern
//   osc_sel, tap_sel         output mux selects
//   res_valid/res_ready      result handshake
//   res_osc, res_tap         pair the result belongs to
//   res_count, res_ovf       counted edges, saturation flag
//   busy, done               activity level, end-of-sweep pulse
// ---------------------------------------------------------------------------
module ro_sweep_ctrl #(
    parameter int N_OSC  = 16,
    parameter int N_TAP  = 5,
    parameter int GATE_W = 16,
    parameter int CNT_W  = 20,
    parameter int SETTLE = 64
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_ni,
    input  logic              sweep_go,
    input  logic              abort,
    input  logic [4:0]        cfg_stage,
    input  logic [GATE_W-1:0] cfg_gate,
    input  logic              ro_in,
    output logic              ro_start,
    output logic [4:0]        ro_stage,
    output logic [3:0]        osc_sel,
    output logic [2:0]        tap_sel,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [3:0]        res_osc,
    output logic [2:0]        res_tap,
    output logic [CNT_W-1:0]  res_count,
    output logic              res_ovf,
    output logic              busy,
    output logic              done
);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] SELECT  = 3'd1;
    localparam logic [2:0] RUN     = 3'd2;
    localparam logic [2:0] MEASURE = 3'd3;
    localparam logic [2:0] REPORT  = 3'd4;
    localparam logic [2:0] NEXT    = 3'd5;
    localparam logic [2:0] DONE    = 3'd6;

    // One timer serves both the settle waits and the gate window.
    localparam int SET_W = $clog2(SETTLE + 1);
    localparam int TMR_W = (GATE_W > SET_W) ? GATE_W : SET_W;
    localparam logic [TMR_W-1:0] SETTLE_LAST = TMR_W'(SETTLE - 1);
    localparam logic [3:0] OSC_LAST = 4'(N_OSC - 1);
    localparam logic [2:0] TAP_LAST = 3'(N_TAP - 1);

    logic [2:0]        state_reg;
    logic [2:0]        state_next;
    logic [TMR_W-1:0]  timer_reg;
    logic [GATE_W-1:0] gate_reg;
    logic [TMR_W-1:0]  gate_last;
    logic [2:0]        sync_reg;
    logic              edge_det;
    logic [CNT_W-1:0]  cnt_reg;
    logic [CNT_W-1:0]  cnt_next;
    logic              ovf_reg;
    logic              ovf_next;
    logic              last_pair;

    // gate_reg is never 0 once latched, so the subtraction cannot wrap
    // while the gate is in use.
    assign gate_last = TMR_W'(gate_reg - GATE_W'(1));
    assign last_pair = (osc_sel == OSC_LAST) && (tap_sel == TAP_LAST);

    // sync_reg[1:0] is the metastability synchronizer; sync_reg[2] holds the
    // previous synchronized value for rising-edge detection.
    assign edge_det = sync_reg[1] & ~sync_reg[2];

    // The counter saturates at all-ones; reaching it flags overflow.
    assign cnt_next = (edge_det && !(&cnt_reg)) ? cnt_reg + CNT_W'(1) : cnt_reg;
    assign ovf_next = ovf_reg | (&cnt_next);

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (sweep_go) state_next = SELECT;
            SELECT:  if (timer_reg == SETTLE_LAST) state_next = RUN;
            RUN:     if (timer_reg == SETTLE_LAST) state_next = MEASURE;
            MEASURE: if (timer_reg == gate_last) state_next = REPORT;
            REPORT:  if (res_ready) state_next = NEXT;
            NEXT:    state_next = last_pair ? DONE : SELECT;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
        // Abort overrides every other transition, including a same-cycle
        // handshake or the end of the gate window.
        if (abort && (state_reg != IDLE)) state_next = IDLE;
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state_reg <= IDLE;
            timer_reg <= '0;
        end else begin
            state_reg <= state_next;
            if (state_next != state_reg)
                timer_reg <= '0;
            else if ((state_reg == SELECT) || (state_reg == RUN) || (state_reg == MEASURE))
                timer_reg <= timer_reg + TMR_W'(1);
            else
                timer_reg <= '0;
        end
    end

    // Configuration latch and select stepping (tap inner, oscillator outer).
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            ro_stage <= '0;
            gate_reg <= '0;
            osc_sel  <= '0;
            tap_sel  <= '0;
        end else if ((state_reg == IDLE) && (state_next == SELECT)) begin
            ro_stage <= cfg_stage;
            gate_reg <= (cfg_gate == '0) ? GATE_W'(1) : cfg_gate;
            osc_sel  <= '0;
            tap_sel  <= '0;
        end else if ((state_reg == NEXT) && !abort) begin
            if (tap_sel == TAP_LAST) begin
                tap_sel <= '0;
                osc_sel <= (osc_sel == OSC_LAST) ? 4'd0 : osc_sel + 4'd1;
            end else begin
                tap_sel <= tap_sel + 3'd1;
            end
        end
    end

    // Synchronizer, edge counter and result registers.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            sync_reg  <= '0;
            cnt_reg   <= '0;
            ovf_reg   <= 1'b0;
            res_osc   <= '0;
            res_tap   <= '0;
            res_count <= '0;
            res_ovf   <= 1'b0;
        end else begin
            sync_reg <= {sync_reg[1:0], ro_in};
            if (state_reg == RUN) begin
                cnt_reg <= '0;
                ovf_reg <= 1'b0;
            end else if (state_reg == MEASURE) begin
                cnt_reg <= cnt_next;
                ovf_reg <= ovf_next;
            end
            // Load from the next-count so an edge in the last gate cycle lands.
            if ((state_reg == MEASURE) && (state_next == REPORT)) begin
                res_osc   <= osc_sel;
                res_tap   <= tap_sel;
                res_count <= cnt_next;
                res_ovf   <= ovf_next;
            end
        end
    end

    // Status outputs decode the state register, so they clear with reset and
    // one cycle after abort.
    assign busy      = (state_reg != IDLE);
    assign done      = (state_reg == DONE);
    assign res_valid = (state_reg == REPORT);
    assign ro_start  = (state_reg == RUN) || (state_reg == MEASURE) || (state_reg == REPORT);

endmodule
